// File: rtl/reg_watch_pkg.sv
// reg_watch_pkg: shared channel state encoding, watch modes and width helper
package reg_watch_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_PASS, ST_FAIL} state_t;
  localparam logic MODE_CHECK = 1'b0;
  localparam logic MODE_WAIT = 1'b1;
  function automatic int ch_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/reg_watch_monitor_if.sv
// reg_watch_monitor_if: register-file snoop, arm request and per-channel status bundle
interface reg_watch_monitor_if
  import reg_watch_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5,
  parameter int TWIDTH = 20
);
  localparam int CWIDTH = ch_w(NUM_CH);
  logic              rf_we;
  logic [AWIDTH-1:0] rf_waddr;
  logic [DWIDTH-1:0] rf_wdata;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CWIDTH-1:0] cfg_ch;
  logic              cfg_mode;
  logic [AWIDTH-1:0] cfg_addr;
  logic [DWIDTH-1:0] cfg_value;
  logic [TWIDTH-1:0] cfg_timeout;
  logic [NUM_CH-1:0] clr;
  logic [NUM_CH-1:0] ch_busy;
  logic [NUM_CH-1:0] ch_pass;
  logic [NUM_CH-1:0] ch_fail;
  logic [NUM_CH-1:0] ch_tmo;
  logic [DWIDTH-1:0] fail_data;
  modport master (
    output rf_we, rf_waddr, rf_wdata, cfg_valid, cfg_ch, cfg_mode, cfg_addr, cfg_value, cfg_timeout, clr,
    input  cfg_ready, ch_busy, ch_pass, ch_fail, ch_tmo, fail_data
  );
  modport slave (
    input  rf_we, rf_waddr, rf_wdata, cfg_valid, cfg_ch, cfg_mode, cfg_addr, cfg_value, cfg_timeout, clr,
    output cfg_ready, ch_busy, ch_pass, ch_fail, ch_tmo, fail_data
  );
endinterface

// File: rtl/reg_watch_channel.sv
// reg_watch_channel: one watch FSM comparing snooped register writes against an armed expectation
module reg_watch_channel
  import reg_watch_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5,
  parameter int TWIDTH = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_arm,
  input  logic              i_clr,
  input  logic              i_mode,
  input  logic [AWIDTH-1:0] i_addr,
  input  logic [DWIDTH-1:0] i_value,
  input  logic [TWIDTH-1:0] i_timeout,
  input  logic              i_rf_we,
  input  logic [AWIDTH-1:0] i_rf_waddr,
  input  logic [DWIDTH-1:0] i_rf_wdata,
  output logic              o_busy,
  output logic              o_pass,
  output logic              o_fail,
  output logic              o_tmo,
  output logic              o_mismatch
);
  state_t            r_state;
  logic              r_mode;
  logic [AWIDTH-1:0] r_addr;
  logic [DWIDTH-1:0] r_value;
  logic [TWIDTH-1:0] r_timeout;
  logic [TWIDTH-1:0] r_cnt;
  logic              w_hit;
  logic              w_eq;
  logic              w_bad_wr;
  logic              w_bad;
  logic              w_tmo;
  logic              w_pass;
  // classify this cycle's write; a watched index of 0 resolves from the value alone
  always_comb begin
    w_hit = i_rf_we && i_rf_waddr != '0 && i_rf_waddr == r_addr;
    w_eq = i_rf_wdata == r_value;
    w_bad_wr = w_hit && r_mode == MODE_CHECK && !w_eq;
    w_bad = r_addr == '0 ? r_value != '0 : w_bad_wr;
    w_tmo = r_timeout != '0 && r_cnt + TWIDTH'(1) == r_timeout;
    w_pass = r_addr == '0 ? r_value == '0 : w_hit && w_eq;
    o_mismatch = r_state == ST_ARMED && !i_arm && !i_clr && w_bad_wr;
  end
  // watch FSM: arm beats clear, clear aborts, a match beats an expiring timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mode <= MODE_CHECK;
      r_addr <= '0;
      r_value <= '0;
      r_timeout <= '0;
      r_cnt <= '0;
      o_busy <= 1'b0;
      o_pass <= 1'b0;
      o_fail <= 1'b0;
      o_tmo <= 1'b0;
    end else if (i_arm) begin
      r_state <= ST_ARMED;
      r_mode <= i_mode;
      r_addr <= i_addr;
      r_value <= i_value;
      r_timeout <= i_timeout;
      r_cnt <= '0;
      o_busy <= 1'b1;
      o_pass <= 1'b0;
      o_fail <= 1'b0;
      o_tmo <= 1'b0;
    end else if (i_clr) begin
      r_state <= ST_IDLE;
      o_busy <= 1'b0;
      o_pass <= 1'b0;
      o_fail <= 1'b0;
      o_tmo <= 1'b0;
    end else if (r_state == ST_ARMED) begin
      r_cnt <= r_cnt + TWIDTH'(1);
      if (w_pass) begin
        r_state <= ST_PASS;
        o_busy <= 1'b0;
        o_pass <= 1'b1;
      end else if (w_bad || w_tmo) begin
        r_state <= ST_FAIL;
        o_busy <= 1'b0;
        o_fail <= 1'b1;
        o_tmo <= !w_bad;
      end
    end
  end
endmodule

// File: rtl/reg_watch_monitor.sv
// reg_watch_monitor: bank of register-write watch channels with shared arm port and failure data capture
module reg_watch_monitor
  import reg_watch_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5,
  parameter int TWIDTH = 20
) (
  input logic clk,
  input logic rst,
  reg_watch_monitor_if.slave bus
);
  localparam int CWIDTH = ch_w(NUM_CH);
  logic [NUM_CH-1:0] w_arm;
  logic [NUM_CH-1:0] w_busy;
  logic [NUM_CH-1:0] w_pass;
  logic [NUM_CH-1:0] w_fail;
  logic [NUM_CH-1:0] w_tmo;
  logic [NUM_CH-1:0] w_mismatch;
  logic              w_ch_ok;
  logic [DWIDTH-1:0] r_fail_data;
  // an arm is accepted only for an existing channel that is not already watching
  always_comb begin
    w_ch_ok = 32'(bus.cfg_ch) < NUM_CH;
    bus.cfg_ready = w_ch_ok && !w_busy[bus.cfg_ch];
    bus.ch_busy = w_busy;
    bus.ch_pass = w_pass;
    bus.ch_fail = w_fail;
    bus.ch_tmo = w_tmo;
    bus.fail_data = r_fail_data;
  end
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_arm[g] = bus.cfg_valid && bus.cfg_ready && bus.cfg_ch == CWIDTH'(g);
    reg_watch_channel #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .TWIDTH(TWIDTH)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_arm     (w_arm[g]),
      .i_clr     (bus.clr[g]),
      .i_mode    (bus.cfg_mode),
      .i_addr    (bus.cfg_addr),
      .i_value   (bus.cfg_value),
      .i_timeout (bus.cfg_timeout),
      .i_rf_we   (bus.rf_we),
      .i_rf_waddr(bus.rf_waddr),
      .i_rf_wdata(bus.rf_wdata),
      .o_busy    (w_busy[g]),
      .o_pass    (w_pass[g]),
      .o_fail    (w_fail[g]),
      .o_tmo     (w_tmo[g]),
      .o_mismatch(w_mismatch[g])
    );
  end
  // every mismatching channel saw the same write, so the lowest-index one's data is simply rf_wdata
  always_ff @(posedge clk) begin
    if (rst) r_fail_data <= '0;
    else if (|w_mismatch) r_fail_data <= bus.rf_wdata;
  end
endmodule

// File: doc/reg_watch_monitor.md
REG_WATCH_MONITOR -- requirements
Module: reg_watch_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent watch channels (1..16).
REQ-002 SHALL have parameter DWIDTH, default 32, register data width.
REQ-003 SHALL have parameter AWIDTH, default 5, register index width.
REQ-004 SHALL have parameter TWIDTH, default 20, timeout counter width.
REQ-005 SHALL have a single clock and a synchronous, active-high reset; ports are named clk and rst.
REQ-006 Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rf_we  in  1  register-file write enable
- rf_waddr  in  AWIDTH  write index
- rf_wdata  in  DWIDTH  write data
- cfg_valid  in  1  arm request
- cfg_ready  out  1  arm accepted
- cfg_ch  in  max(1,clog2(NUM_CH))  target channel
- cfg_mode  in  1  0=CHECK, 1=WAIT
- cfg_addr  in  AWIDTH  watched index
- cfg_value  in  DWIDTH  expected value
- cfg_timeout  in  TWIDTH  cycle limit, 0=none
- clr  in  NUM_CH  per-channel return-to-IDLE
- ch_busy  out  NUM_CH  channel ARMED
- ch_pass  out  NUM_CH  channel PASS
- ch_fail  out  NUM_CH  channel FAIL
- ch_tmo  out  NUM_CH  FAIL caused by timeout
- fail_data  out  DWIDTH  data of most recent mismatching write, any channel

Function
REQ-007 Each channel SHALL be an FSM with states IDLE, ARMED, PASS, FAIL; ch_busy/ch_pass/ch_fail SHALL be registered decodes of the state.
REQ-008 cfg_ready SHALL be combinational: high iff channel cfg_ch is not ARMED.
REQ-009 On cfg_valid&&cfg_ready, the target channel SHALL latch mode/addr/value/timeout and enter ARMED on the next edge; ch_tmo SHALL clear.
REQ-010 A write in the arming cycle SHALL NOT be evaluated; evaluation SHALL start the cycle after arm.
REQ-011 Writes with rf_waddr==0 SHALL be ignored.
REQ-012 CHECK mode: the first qualifying write to cfg_addr SHALL go to PASS if rf_wdata==cfg_value, else FAIL with fail_data<=rf_wdata.
REQ-013 WAIT mode: a qualifying write equal to cfg_value SHALL go to PASS; non-equal writes SHALL be ignored.
REQ-014 Arm with cfg_addr==0 SHALL resolve on the next edge: PASS if cfg_value==0, else FAIL.
REQ-015 With cfg_timeout=T>0, the channel SHALL go to FAIL with ch_tmo=1 at the end of the T-th ARMED cycle if unresolved.
REQ-016 A match in the same cycle as timeout expiry SHALL yield PASS.
REQ-017 Decision latency SHALL be one cycle: a write at edge N is reflected in outputs after edge N+1.
REQ-018 clr[i] SHALL move PASS/FAIL to IDLE; clr[i] on ARMED SHALL abort to IDLE; clr on the channel being armed in the same cycle SHALL lose to the arm.
REQ-019 Channels SHALL evaluate independently; several may resolve on the same write.
REQ-020 If several channels mismatch in one cycle, fail_data SHALL take the lowest-index channel's data, which is rf_wdata in all cases.
REQ-021 cfg_ch >= NUM_CH SHALL hold cfg_ready low and arm nothing.

Reset
REQ-022 rst SHALL force all channels to IDLE, clear all outputs, latched fields and counters to 0, and abort any armed watch.

Structure
REQ-023 Package reg_watch_pkg SHALL hold the state enum and MODE_CHECK/MODE_WAIT constants.
REQ-024 Per-channel logic SHALL be sub-module reg_watch_channel, generated NUM_CH times; the top SHALL hold only the arm decode and fail_data merge.

Verification
REQ-025 Bench SHALL cover:
- CHECK ch0 addr 5 value 0x2A, write x5=0x2A -> ch_pass[0]=1 one cycle later.
- CHECK ch1 addr 7 value 3, write x7=4 -> ch_fail[1]=1, fail_data=4, ch_tmo[1]=0.
- WAIT ch2 addr 10 value 9 timeout 8, writes x10=1,2 and no match -> ch_fail[2]=1, ch_tmo[2]=1 after exactly 8 armed cycles; repeat with x10=9 on cycle 8 -> PASS.
- Re-arm ARMED ch0 -> cfg_ready=0; clr[0] -> IDLE, then arm is accepted.
- Arm in the same cycle as a matching write -> write ignored, channel stays ARMED; ch0 and ch3 both WAIT on x2=0x100 -> both PASS on one write.
- rst asserted mid-ARMED -> all outputs 0 next edge; addr-0 arm with value 0 -> PASS.
